snn_neuron_scheduler: RTL and testbench



---
 rtl/snn_pkg.sv | 31 +++
 rtl/fifo.sv | 64 ++++++
 rtl/snn_neuron_scheduler_neuron_update.sv | 29 ++
 rtl/snn_neuron_scheduler.sv | 121 ++++++++++++
 tb/tb_snn_neuron_scheduler.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron scheduler and its datapath.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package snn_pkg;

  typedef logic signed [7:0] vmem_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_UPDATE,
    ST_DONE
  } state_e;

  localparam vmem_t V_TH_DEF    = 8'sd50;
  localparam vmem_t V_RESET_DEF = -8'sd20;

  // Wide enough for V + I/4 + (V/8)^2 at any 8-bit input without wrap.
  localparam int SUM_W = 12;

  function automatic vmem_t sat8(input logic signed [SUM_W-1:0] x);
    if (x > 12'sd127) begin
      return 8'sd127;
    end else if (x < -12'sd128) begin
      return -8'sd128;
    end else begin
      return x[7:0];
    end
  endfunction

endpackage

// File: rtl/fifo.sv
// Generic valid/ready FIFO; DEPTH must be a power of two and at least 2.
// Latency: pushed data is visible at the head one cycle after the push.
// Backpressure: push_rdy drops when full unless a pop is accepted in the same cycle.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          push_fire, pop_fire;

  always_comb begin
    pop_vld   = (cnt_q != '0);
    pop_fire  = pop_vld && pop_rdy;
    push_rdy  = (cnt_q != (PW+1)'(DEPTH)) || pop_rdy;
    push_fire = push_vld && push_rdy;
    pop_dat   = mem_q[rd_q];
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    // When full, the write slot is the head slot; the head is read from mem_q so both succeed.
    if (push_fire) begin
      mem_d[wr_q] = push_dat;
      wr_d        = wr_q + PW'(1);
    end
    if (pop_fire) begin
      rd_d = rd_q + PW'(1);
    end
    case ({push_fire, pop_fire})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < DEPTH; n++) mem_q[n] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snn_neuron_scheduler_neuron_update.sv
// Quadratic integrate-and-fire update for one neuron.
// Latency: combinational.
// Backpressure: none.
module neuron_update
  import snn_pkg::*;
(
  input  vmem_t v_i,
  input  vmem_t i_i,
  input  vmem_t v_th_i,
  input  vmem_t v_reset_i,
  output vmem_t v_next_o,
  output logic  spike_o
);
  localparam logic signed [SUM_W-1:0] DIV4 = 12'sd4;
  localparam logic signed [SUM_W-1:0] DIV8 = 12'sd8;

  logic signed [SUM_W-1:0] v_w, i_w, v_div8, sum;

  always_comb begin
    v_w      = {{(SUM_W-8){v_i[7]}}, v_i};
    i_w      = {{(SUM_W-8){i_i[7]}}, i_i};
    // Signed division truncates toward zero, which is the intended rounding.
    v_div8   = v_w / DIV8;
    sum      = v_w + i_w / DIV4 + v_div8 * v_div8;
    spike_o  = (v_i >= v_th_i);
    v_next_o = spike_o ? v_reset_i : sat8(sum);
  end

endmodule

// File: rtl/snn_neuron_scheduler.sv
// Sweeps all neurons through one shared update datapath per timestep and queues spikes.
// Latency: 2 cycles per neuron plus one DONE cycle; the spike FIFO head is valid one cycle after the push.
// Backpressure: spike_ready_i low fills the FIFO; further spikes are dropped and flagged, the sweep never stalls.
module snn_neuron_scheduler
  import snn_pkg::*;
#(
  parameter int    N_NEURONS  = 8,
  parameter int    AW         = $clog2(N_NEURONS),
  parameter vmem_t V_TH       = V_TH_DEF,
  parameter vmem_t V_RESET    = V_RESET_DEF,
  parameter int    FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] isyn_addr_o,
  input  logic [7:0]    isyn_data_i,
  output logic          spike_valid_o,
  input  logic          spike_ready_i,
  output logic [AW-1:0] spike_id_o,
  input  logic [AW-1:0] vmem_addr_i,
  output logic [7:0]    vmem_data_o,
  output logic          overflow_o,
  output logic          overrun_o
);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  vmem_t         vmem_q [N_NEURONS];
  vmem_t         vmem_d [N_NEURONS];
  logic          overflow_q, overflow_d;
  logic          overrun_q, overrun_d;
  vmem_t         v_next;
  logic          fire, upd_vld, push_vld, push_rdy;

  neuron_update u_neuron_update (
    .v_i       (vmem_q[idx_q]),
    .i_i       (vmem_t'(isyn_data_i)),
    .v_th_i    (V_TH),
    .v_reset_i (V_RESET),
    .v_next_o  (v_next),
    .spike_o   (fire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
      for (int n = 0; n < N_NEURONS; n++) vmem_q[n] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      overrun_q  <= overrun_d;
      vmem_q     <= vmem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (step_i) begin
          state_d = ST_FETCH;
          idx_d   = '0;
        end
      end
      ST_FETCH:  state_d = ST_UPDATE;
      ST_UPDATE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FETCH;
          idx_d   = idx_q + AW'(1);
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    done_o      = (state_q == ST_DONE);
    upd_vld     = (state_q == ST_UPDATE);
    isyn_addr_o = idx_q;
  end

  always_comb begin
    vmem_d = vmem_q;
    if (upd_vld) vmem_d[idx_q] = v_next;
    push_vld   = upd_vld && fire;
    overflow_d = overflow_q | (push_vld & ~push_rdy);
    overrun_d  = overrun_q | (step_i & (state_q != ST_IDLE));
  end

  fifo #(
    .W     (AW),
    .DEPTH (FIFO_DEPTH)
  ) u_spike_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_dat (idx_q),
    .push_rdy (push_rdy),
    .pop_vld  (spike_valid_o),
    .pop_rdy  (spike_ready_i),
    .pop_dat  (spike_id_o)
  );

  assign vmem_data_o = vmem_q[vmem_addr_i];
  assign overflow_o  = overflow_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_snn_neuron_scheduler.sv
// Directed bench for snn_neuron_scheduler: default instance A plus a V_TH=127 instance B.
`timescale 1ns/1ps
module tb_snn_neuron_scheduler;
  localparam int N  = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          step_a = 1'b0, step_b = 1'b0;
  logic          busy_a, done_a, sv_a, of_a, or_a;
  logic          busy_b, done_b, sv_b, of_b, or_b;
  logic          sr_a = 1'b0, sr_b = 1'b0;
  logic [AW-1:0] ia_a, ia_b, sid_a, sid_b;
  logic [AW-1:0] va_a = '0, va_b = '0;
  logic [7:0]    idat_a, idat_b, vd_a, vd_b;
  logic [7:0]    cur_a [N];
  logic [7:0]    cur_b [N];

  int tests = 0;
  int fails = 0;

  // Synchronous-read current memories: data valid one cycle after the address.
  always @(posedge clk) begin
    idat_a <= cur_a[ia_a];
    idat_b <= cur_b[ia_b];
  end

  snn_neuron_scheduler u_dut_a (
    .clk(clk), .rst_n(rst_n), .step_i(step_a), .busy_o(busy_a), .done_o(done_a),
    .isyn_addr_o(ia_a), .isyn_data_i(idat_a), .spike_valid_o(sv_a), .spike_ready_i(sr_a),
    .spike_id_o(sid_a), .vmem_addr_i(va_a), .vmem_data_o(vd_a), .overflow_o(of_a), .overrun_o(or_a)
  );

  snn_neuron_scheduler #(.V_TH(8'sd127)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .step_i(step_b), .busy_o(busy_b), .done_o(done_b),
    .isyn_addr_o(ia_b), .isyn_data_i(idat_b), .spike_valid_o(sv_b), .spike_ready_i(sr_b),
    .spike_id_o(sid_b), .vmem_addr_i(va_b), .vmem_data_o(vd_b), .overflow_o(of_b), .overrun_o(or_b)
  );

  task automatic set_all_cur(input logic [7:0] v);
    for (int j = 0; j < N; j++) cur_a[j] = v;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Pulses step, waits for done (bounded) and then one more edge so the FSM is back in IDLE.
  task automatic do_step(input bit use_b);
    bit seen;
    seen = 1'b0;
    if (use_b) step_b = 1'b1; else step_a = 1'b1;
    @(posedge clk); #1;
    step_a = 1'b0;
    step_b = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if ((use_b ? done_b : done_a) === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL step_timeout: done_o not seen within 40 cycles (inst_b=%0d)", use_b);
    end
  endtask

  task automatic test_reset;
    #1;
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done_a); end
    tests++; if (sv_a !== 1'b0) begin fails++; $display("FAIL reset_spike_valid: got %b want 0", sv_a); end
    tests++; if (of_a !== 1'b0 || or_a !== 1'b0) begin fails++; $display("FAIL reset_sticky: got of=%b or=%b want 0 0", of_a, or_a); end
    tests++; if (ia_a !== 3'd0) begin fails++; $display("FAIL reset_isyn_addr: got %0d want 0", ia_a); end
    for (int j = 0; j < N; j++) begin
      va_a = j[AW-1:0]; #0.5;
      tests++; if (vd_a !== 8'd0) begin fails++; $display("FAIL reset_vmem[%0d]: got %0d want 0", j, $signed(vd_a)); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_sweep;
    int dones;
    dones = 0;
    set_all_cur(8'd0);
    step_a = 1'b1;
    @(posedge clk); #1;
    step_a = 1'b0;
    for (int n = 0; n <= 20; n++) begin
      if (done_a === 1'b1) dones++;
      tests++; if (done_a !== (n == 16)) begin fails++; $display("FAIL zero_done_cycle%0d: got %b want %b", n, done_a, (n == 16)); end
      tests++; if (busy_a !== (n <= 16)) begin fails++; $display("FAIL zero_busy_cycle%0d: got %b want %b", n, busy_a, (n <= 16)); end
      tests++; if (sv_a !== 1'b0) begin fails++; $display("FAIL zero_spike_cycle%0d: got %b want 0", n, sv_a); end
      @(posedge clk); #1;
    end
    tests++; if (dones != 1) begin fails++; $display("FAIL zero_done_count: got %0d want 1", dones); end
    for (int j = 0; j < N; j++) begin
      va_a = j[AW-1:0]; #0.5;
      tests++; if (vd_a !== 8'd0) begin fails++; $display("FAIL zero_vmem[%0d]: got %0d want 0", j, $signed(vd_a)); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_integrate;
    logic [7:0] exp_v [5];
    exp_v = '{8'd10, 8'd21, 8'd35, 8'd61, 8'hEC};
    set_all_cur(8'd0);
    cur_a[3] = 8'd40;
    for (int s = 0; s < 5; s++) begin
      do_step(1'b0);
      va_a = 3'd3; #0.5;
      tests++; if (vd_a !== exp_v[s]) begin fails++; $display("FAIL integ_vmem3_step%0d: got %0d want %0d", s + 1, $signed(vd_a), $signed(exp_v[s])); end
      va_a = 3'd2; #0.5;
      tests++; if (vd_a !== 8'd0) begin fails++; $display("FAIL integ_vmem2_step%0d: got %0d want 0", s + 1, $signed(vd_a)); end
      tests++; if (sv_a !== (s == 4)) begin fails++; $display("FAIL integ_spike_valid_step%0d: got %b want %b", s + 1, sv_a, (s == 4)); end
      @(posedge clk); #1;
    end
    tests++; if (sid_a !== 3'd3) begin fails++; $display("FAIL integ_spike_id: got %0d want 3", sid_a); end
    sr_a = 1'b1;
    @(posedge clk); #1;
    sr_a = 1'b0;
    tests++; if (sv_a !== 1'b0) begin fails++; $display("FAIL integ_single_spike: got valid %b want 0", sv_a); end
    cur_a[3] = 8'd0;
  endtask

  task automatic test_saturate;
    logic [7:0] exp_v [4];
    exp_v = '{8'd31, 8'd71, 8'd127, 8'hEC};
    for (int j = 0; j < N; j++) cur_b[j] = 8'd0;
    cur_b[0] = 8'd127;
    for (int s = 0; s < 4; s++) begin
      do_step(1'b1);
      va_b = 3'd0; #0.5;
      tests++; if (vd_b !== exp_v[s]) begin fails++; $display("FAIL sat_vmem0_step%0d: got %0d want %0d", s + 1, $signed(vd_b), $signed(exp_v[s])); end
      tests++; if (sv_b !== (s == 3)) begin fails++; $display("FAIL sat_spike_valid_step%0d: got %b want %b", s + 1, sv_b, (s == 3)); end
      @(posedge clk); #1;
    end
    tests++; if (sid_b !== 3'd0) begin fails++; $display("FAIL sat_spike_id: got %0d want 0", sid_b); end
    sr_b = 1'b1;
    @(posedge clk); #1;
    sr_b = 1'b0;
    tests++; if (sv_b !== 1'b0) begin fails++; $display("FAIL sat_one_spike: got valid %b want 0", sv_b); end
    tests++; if (of_b !== 1'b0 || or_b !== 1'b0 || busy_b !== 1'b0) begin fails++; $display("FAIL sat_flags: got of=%b or=%b busy=%b want 0 0 0", of_b, or_b, busy_b); end
  endtask

  task automatic test_overflow;
    pulse_reset();
    set_all_cur(8'd127);
    sr_a = 1'b0;
    do_step(1'b0);
    do_step(1'b0);
    tests++; if (of_a !== 1'b0 || sv_a !== 1'b0) begin fails++; $display("FAIL ovf_pre: got of=%b valid=%b want 0 0", of_a, sv_a); end
    do_step(1'b0);
    tests++; if (of_a !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b want 1", of_a); end
    va_a = 3'd7; #0.5;
    tests++; if (vd_a !== 8'hEC) begin fails++; $display("FAIL ovf_vmem7: got %0d want -20", $signed(vd_a)); end
    @(posedge clk); #1;
    sr_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (sv_a !== 1'b1 || sid_a !== i[AW-1:0]) begin fails++; $display("FAIL ovf_pop%0d: got valid=%b id=%0d want 1 %0d", i, sv_a, sid_a, i); end
      @(posedge clk); #1;
    end
    sr_a = 1'b0;
    tests++; if (sv_a !== 1'b0) begin fails++; $display("FAIL ovf_drained: got valid %b want 0", sv_a); end
    tests++; if (of_a !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", of_a); end
  endtask

  task automatic test_overrun;
    int dones;
    dones = 0;
    pulse_reset();
    set_all_cur(8'd0);
    tests++; if (or_a !== 1'b0) begin fails++; $display("FAIL overrun_pre: got %b want 0", or_a); end
    step_a = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n <= 20; n++) begin
      step_a = (n == 4);
      if (n == 4) begin
        tests++; if (ia_a !== 3'd2 || busy_a !== 1'b1) begin fails++; $display("FAIL overrun_fetch2: got addr=%0d busy=%b want 2 1", ia_a, busy_a); end
      end
      if (done_a === 1'b1) dones++;
      tests++; if (done_a !== (n == 16)) begin fails++; $display("FAIL overrun_done_cycle%0d: got %b want %b", n, done_a, (n == 16)); end
      @(posedge clk); #1;
    end
    step_a = 1'b0;
    tests++; if (dones != 1) begin fails++; $display("FAIL overrun_done_count: got %0d want 1", dones); end
    tests++; if (or_a !== 1'b1) begin fails++; $display("FAIL overrun_flag: got %b want 1", or_a); end
  endtask

  task automatic test_reset_mid;
    pulse_reset();
    set_all_cur(8'd0);
    cur_a[0] = 8'd127;
    cur_a[1] = 8'd127;
    sr_a = 1'b0;
    do_step(1'b0);
    do_step(1'b0);
    step_a = 1'b1;
    @(posedge clk); #1;
    step_a = 1'b0;
    for (int n = 0; n < 11; n++) begin
      @(posedge clk); #1;
    end
    tests++; if (ia_a !== 3'd5 || sv_a !== 1'b1) begin fails++; $display("FAIL mid_pre: got addr=%0d valid=%b want 5 1", ia_a, sv_a); end
    rst_n = 1'b0;
    #0.5;
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", busy_a); end
    tests++; if (sv_a !== 1'b0) begin fails++; $display("FAIL mid_spike_valid: got %b want 0", sv_a); end
    for (int j = 0; j < N; j++) begin
      va_a = j[AW-1:0]; #0.5;
      tests++; if (vd_a !== 8'd0) begin fails++; $display("FAIL mid_vmem[%0d]: got %0d want 0", j, $signed(vd_a)); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_all_cur(8'd0);
    @(posedge clk); #1;
    do_step(1'b0);
    tests++; if (sv_a !== 1'b0 || busy_a !== 1'b0) begin fails++; $display("FAIL mid_resweep: got valid=%b busy=%b want 0 0", sv_a, busy_a); end
    for (int j = 0; j < N; j++) begin
      va_a = j[AW-1:0]; #0.5;
      tests++; if (vd_a !== 8'd0) begin fails++; $display("FAIL mid_resweep_vmem[%0d]: got %0d want 0", j, $signed(vd_a)); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    set_all_cur(8'd0);
    for (int j = 0; j < N; j++) cur_b[j] = 8'd0;
    test_reset();
    test_zero_sweep();
    test_integrate();
    test_saturate();
    test_overflow();
    test_overrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
